// File: rtl/gpio_cfg_serializer_if.sv
// Parallel-side and chain-side signals of the GPIO configuration serializer.
// master = management side driving start/cfg_data, slave = the serializer.
interface gpio_cfg_serializer_if #(
    parameter int PADS     = 38,
    parameter int CFG_BITS = 13
);
    logic                       start;
    logic [PADS*CFG_BITS-1:0]   cfg_data;
    logic                       busy;
    logic                       done;
    logic                       serial_clock;
    logic                       serial_data;
    logic                       serial_load;
    logic                       serial_resetn;

    modport master (
        output start, cfg_data,
        input  busy, done, serial_clock, serial_data, serial_load, serial_resetn
    );

    modport slave (
        input  start, cfg_data,
        output busy, done, serial_clock, serial_data, serial_load, serial_resetn
    );
endinterface

// File: rtl/gpio_cfg_serializer.sv
// Shifts a PADS*CFG_BITS pad configuration image out over a divided chain clock, then strobes load.
// Optional chain reset phase before shifting: define GPIO_CFG_CHAIN_RESET_EN.
module gpio_cfg_serializer #(
    parameter int PADS     = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    gpio_cfg_serializer_if.slave bus
);
    localparam int TOTAL = PADS * CFG_BITS;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int HW    = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] TOTAL_CNT = BW'(TOTAL);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        FIN
`ifdef GPIO_CFG_CHAIN_RESET_EN
        , CHAIN_RST
`endif
    } state_t;

    state_t           state;
    logic [TOTAL-1:0] shreg;
    logic [BW-1:0]    bcnt;
    logic [HW-1:0]    hcnt;
`ifdef GPIO_CFG_CHAIN_RESET_EN
    logic             rst_half;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state             <= IDLE;
            shreg             <= '0;
            bcnt              <= '0;
            hcnt              <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.serial_clock  <= 1'b0;
            bus.serial_data   <= 1'b0;
            bus.serial_load   <= 1'b0;
            bus.serial_resetn <= 1'b1;
`ifdef GPIO_CFG_CHAIN_RESET_EN
            rst_half          <= 1'b0;
`endif
        end else begin
            // Outputs are decoded from the state held this cycle, so they trail it by one edge;
            // data and clock therefore always update together on the same edge.
            bus.busy         <= (state != IDLE) && (state != FIN);
            bus.done         <= (state == FIN);
            bus.serial_clock <= (state == SHIFT_HI);
            bus.serial_data  <= ((state == SHIFT_LO) || (state == SHIFT_HI)) && shreg[TOTAL-1];
            bus.serial_load  <= (state == LOAD);
`ifdef GPIO_CFG_CHAIN_RESET_EN
            bus.serial_resetn <= (state != CHAIN_RST);
`else
            bus.serial_resetn <= 1'b1;
`endif

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg <= bus.cfg_data;
                        bcnt  <= TOTAL_CNT;
                        hcnt  <= '0;
`ifdef GPIO_CFG_CHAIN_RESET_EN
                        rst_half <= 1'b0;
                        state    <= CHAIN_RST;
`else
                        state    <= SHIFT_LO;
`endif
                    end
                end
`ifdef GPIO_CFG_CHAIN_RESET_EN
                // Two half-periods of reset, counted as two passes of the half counter.
                CHAIN_RST: begin
                    if (hcnt == HALF_LAST) begin
                        hcnt     <= '0;
                        rst_half <= ~rst_half;
                        if (rst_half) state <= SHIFT_LO;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
`endif
                SHIFT_LO: begin
                    if (hcnt == HALF_LAST) begin
                        hcnt  <= '0;
                        state <= SHIFT_HI;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (hcnt == HALF_LAST) begin
                        hcnt  <= '0;
                        shreg <= shreg << 1;
                        bcnt  <= bcnt - BW'(1);
                        state <= (bcnt == BW'(1)) ? LOAD : SHIFT_LO;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                LOAD: begin
                    if (hcnt == HALF_LAST) begin
                        hcnt  <= '0;
                        state <= FIN;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gpio_cfg_serializer.md
Name: gpio_cfg_serializer

Overview:
- Transmitter end of the user-area GPIO serial configuration chain.
- Takes a parallel configuration image for all user pads and shifts it out bit-serially over a generated chain clock. When shifting is complete it pulses a load strobe.
- The per-pad control blocks at the far end of the chain latch the image and drive the pad-array control inputs: oeb, dm, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover, analog_*.
- Sits in the housekeeping domain, between the management register file and the pad control chain.

Parameters:
- PADS, 38, number of pads on the chain.
- CFG_BITS, 13, configuration bits per pad.
- CLK_DIV, 2, half-period of serial_clock in wb_clk_i cycles (legal range 1..255).

Ports:
- wb_clk_i  input  1  system clock; all logic on the rising edge.
- wb_rst_i  input  1  reset, synchronous, active-high.
- start  input  1  begin a transfer; sampled only in IDLE.
- cfg_data  input  PADS*CFG_BITS  configuration image; pad p occupies bits [p*CFG_BITS +: CFG_BITS].
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when the transfer completes.
- serial_clock  output  1  chain shift clock.
- serial_data  output  1  chain data; stable for the whole serial_clock high phase.
- serial_load  output  1  chain latch strobe.
- serial_resetn  output  1  chain reset, active-low.

Behaviour:
- Reset: all outputs take their idle values at the next edge, including mid-transfer:
  - busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0, serial_resetn=1.
  - FSM goes to IDLE; the half-period counter and bit counter clear.
  - A transfer interrupted by reset is abandoned. No load pulse is issued.
- Constants: TOTAL = PADS*CFG_BITS. Bit counter width = clog2(TOTAL+1). Half-period counter width = clog2(CLK_DIV+1).
- IDLE:
  - With start=1 at edge k, capture cfg_data into the shift register and set bit count to TOTAL.
  - busy=1 from edge k+1; enter SHIFT_LO (or CHAIN_RST if the optional feature is compiled in).
  - cfg_data changes after edge k do not affect the transfer.
- Bit order: pad PADS-1 first, MSB first within each pad; pad 0 bit 0 is shifted last. serial_data = shift register MSB.
- SHIFT_LO: serial_clock=0 for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - serial_clock=1 for CLK_DIV cycles.
  - On exit: shift register shifts left by 1 and bit count decrements.
  - Next state is LOAD if the count reaches 0, else SHIFT_LO.
- LOAD: serial_clock=0, serial_data=0, serial_load=1 for CLK_DIV cycles, then go to FIN.
- FIN (one cycle): done=1, busy=0, serial_load=0. Next state IDLE.
- Timing: done is high in the cycle after edge k+1+2*CLK_DIV*TOTAL+CLK_DIV.
- start while busy or in FIN: ignored, no queuing. start held high in IDLE after FIN begins a new transfer.
- serial_data changes only on the SHIFT_HI→SHIFT_LO transition or on entry to SHIFT_LO. It never changes while serial_clock=1.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: GPIO_CFG_CHAIN_RESET_EN.
- Defined:
  - After start, the FSM enters CHAIN_RST before SHIFT_LO.
  - In CHAIN_RST: serial_resetn=0 for 2*CLK_DIV cycles, serial_clock=0, serial_data=0.
  - Transfer latency grows by 2*CLK_DIV cycles.
- Undefined: no CHAIN_RST state; serial_resetn is held at 1 permanently.

Test Plan:
- Idle reset: PADS=2, CFG_BITS=4, CLK_DIV=1; assert wb_rst_i for 2 cycles → all outputs at idle values, busy=0.
- Bit order: cfg_data=8'hA5, start pulse at edge k (macro undefined) →
  - serial_data sampled on each serial_clock rising edge = 1,0,1,0,0,1,0,1.
  - serial_load high exactly 1 cycle at k+17.
  - done high at k+18.
- Clock divide: CLK_DIV=3, same image → serial_clock high 3 cycles and low 3 cycles per bit; 8 rising edges total; serial_load high 3 cycles.
- Start ignored and input isolation: start held high during the whole transfer, cfg_data changed to 8'hFF mid-transfer → exactly one transfer of 8'hA5; next transfer starts the cycle after FIN.
- Reset mid-operation: assert wb_rst_i after 3 serial_clock edges → next edge all outputs idle; no serial_load pulse; done stays 0.
- Macro defined: CLK_DIV=1 → serial_resetn=0 for 2 cycles starting k+1, first serial_clock rise at k+4, done at k+20.
